// File: rtl/dmem_responder.sv
// dmem_responder: word memory with 1-cycle registered processor port and a non-stalling debug read port.
// Optional DMEM_CLEAR_ON_RESET_EN: zero every word in an INIT sequence after reset.
module dmem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              init_busy
);
  typedef enum logic {D_IDLE, D_BUSY} dstate_t;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              run;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  dstate_t           dstate;
`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= RUN;
    end
  assign run       = state == RUN;
  assign init_busy = state == INIT;
  assign wr_en     = !reset && (run ? wren : 1'b1);
  assign wr_addr   = run ? address_dmem : cnt;
  assign wr_data   = run ? data : '0;
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
  assign wr_en     = !reset && wren;
  assign wr_addr   = address_dmem;
  assign wr_data   = data;
`endif
  // Memory is not reset so contents survive reset when no clear sequence runs.
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clock)
    if (reset || !run) q_dmem <= '0;
    else q_dmem <= mem[address_dmem];
  // Debug data is sampled at the accept edge, before any same-edge processor write lands.
  always_ff @(posedge clock)
    if (reset) begin
      dstate    <= D_IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else if (dstate == D_BUSY) begin
      dstate  <= D_IDLE;
      dbg_ack <= 1'b0;
    end else if (dbg_req && run) begin
      dstate    <= D_BUSY;
      dbg_ack   <= 1'b1;
      dbg_rdata <= mem[dbg_addr];
    end else begin
      dbg_ack <= 1'b0;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven check of processor/debug ports plus reset and clear sequences.
module tb_dmem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        dbg_req = 1'b0;
  logic [3:0]  dbg_addr = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        init_busy;
  int checks = 0;
  int failures = 0;

  dmem_responder #(.ADDR_W(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .init_busy(init_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic        dreq;
    logic [3:0]  daddr;
    logic        chk_q;
    logic [31:0] q;
    logic        ack;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t v(logic wr, logic [3:0] addr, logic [31:0] wd, logic dreq,
                             logic [3:0] daddr, logic chk_q, logic [31:0] q, logic ack,
                             logic [31:0] rd);
    v = '{wr, addr, wd, dreq, daddr, chk_q, q, ack, rd};
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic count_init(input string name, input int exp);
    int n = 0;
    while (init_busy && n < 40) begin
      n++;
      step();
    end
    chk(name, n, exp);
  endtask

  initial begin
    vecs[0]  = v(1'b1, 4'd1, 32'd345,      1'b0, 4'd0, 1'b0, 32'd0,        1'b0, 32'd0);
    vecs[1]  = v(1'b1, 4'd2, 32'd567,      1'b0, 4'd0, 1'b0, 32'd0,        1'b0, 32'd0);
    vecs[2]  = v(1'b0, 4'd1, 32'd0,        1'b0, 4'd0, 1'b1, 32'd345,      1'b0, 32'd0);
    vecs[3]  = v(1'b0, 4'd2, 32'd0,        1'b0, 4'd0, 1'b1, 32'd567,      1'b0, 32'd0);
    vecs[4]  = v(1'b1, 4'd5, 32'h11,       1'b0, 4'd0, 1'b0, 32'd0,        1'b0, 32'd0);
    vecs[5]  = v(1'b1, 4'd5, 32'h22,       1'b0, 4'd0, 1'b1, 32'h11,       1'b0, 32'd0);
    vecs[6]  = v(1'b0, 4'd5, 32'd0,        1'b0, 4'd0, 1'b1, 32'h22,       1'b0, 32'd0);
    vecs[7]  = v(1'b1, 4'd7, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'd0,        1'b0, 32'd0);
    vecs[8]  = v(1'b1, 4'd7, 32'h1,        1'b1, 4'd7, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    vecs[9]  = v(1'b0, 4'd7, 32'd0,        1'b0, 4'd0, 1'b1, 32'h1,        1'b0, 32'hDEADBEEF);
    vecs[10] = v(1'b0, 4'd1, 32'd0,        1'b1, 4'd2, 1'b1, 32'd345,      1'b1, 32'd567);
    vecs[11] = v(1'b0, 4'd2, 32'd0,        1'b1, 4'd1, 1'b1, 32'd567,      1'b0, 32'd567);
    vecs[12] = v(1'b0, 4'd2, 32'd0,        1'b1, 4'd1, 1'b1, 32'd567,      1'b1, 32'd345);
    vecs[13] = v(1'b0, 4'd5, 32'd0,        1'b1, 4'd5, 1'b1, 32'h22,       1'b0, 32'd345);
    vecs[14] = v(1'b0, 4'd5, 32'd0,        1'b1, 4'd5, 1'b1, 32'h22,       1'b1, 32'h22);
    vecs[15] = v(1'b0, 4'd7, 32'd0,        1'b0, 4'd0, 1'b1, 32'h1,        1'b0, 32'h22);

    step();
    chk("reset_q", q_dmem, 32'd0);
    chk("reset_ack", {31'd0, dbg_ack}, 32'd0);
    chk("reset_rdata", dbg_rdata, 32'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    reset = 1'b0;
    count_init("first_init_len", 16);
`else
    chk("reset_busy", {31'd0, init_busy}, 32'd0);
    reset = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      wren = vecs[i].wr; address_dmem = vecs[i].addr; data = vecs[i].wd;
      dbg_req = vecs[i].dreq; dbg_addr = vecs[i].daddr;
      step();
      if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), q_dmem, vecs[i].q);
      chk($sformatf("vec%0d_ack", i), {31'd0, dbg_ack}, {31'd0, vecs[i].ack});
      chk($sformatf("vec%0d_rdata", i), dbg_rdata, vecs[i].rd);
    end
    wren = 1'b0; dbg_req = 1'b0;

    // Reset with a debug request pending must discard it.
    dbg_req = 1'b1; dbg_addr = 4'd7;
    wren = 1'b1; address_dmem = 4'd3; data = 32'hA5;
    reset = 1'b1;
    step();
    chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_q", q_dmem, 32'd0);
    dbg_req = 1'b0; wren = 1'b0;

`ifdef DMEM_CLEAR_ON_RESET_EN
    reset = 1'b0;
    count_init("init_len_a", 16);
    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; address_dmem = 4'(i); data = 32'h100 + 32'(i);
      step();
    end
    wren = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    begin
      int n = 0;
      bit bad = 1'b0;
      wren = 1'b1; data = 32'hFFFF; dbg_req = 1'b1; dbg_addr = 4'd3;
      while (init_busy && n < 40) begin
        address_dmem = 4'(n);
        n++;
        step();
        if (dbg_ack || q_dmem != 32'd0) bad = 1'b1;
      end
      chk("init_len_preload", n, 16);
      chk("init_ignores_io", {31'd0, bad}, 32'd0);
    end
    wren = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address_dmem = 4'(i);
      step();
      if (i > 0) chk($sformatf("cleared_%0d", i - 1), q_dmem, 32'd0);
    end
    step();
    chk("cleared_15", q_dmem, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_init_busy", {31'd0, init_busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_init("init_len_restart", 16);
`else
    wren = 1'b1; address_dmem = 4'd3; data = 32'hA5;
    reset = 1'b0;
    step();
    wren = 1'b0;
    reset = 1'b1;
    step();
    chk("rst2_busy", {31'd0, init_busy}, 32'd0);
    reset = 1'b0;
    address_dmem = 4'd3;
    step();
    chk("preserved_mem3", q_dmem, 32'hA5);
    chk("run_busy", {31'd0, init_busy}, 32'd0);
    address_dmem = 4'd2;
    step();
    chk("preserved_mem2", q_dmem, 32'd567);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address_dmem  input  ADDR_W  processor word address.
REQ-006 SHALL have port data  input  DATA_W  processor store data.
REQ-007 SHALL have port wren  input  1  processor write enable.
REQ-008 SHALL have port q_dmem  output  DATA_W  processor load data, registered.
REQ-009 SHALL have port dbg_req  input  1  debug read request, level.
REQ-010 SHALL have port dbg_addr  input  ADDR_W  debug read word address.
REQ-011 SHALL have port dbg_ack  output  1  debug read-complete pulse.
REQ-012 SHALL have port dbg_rdata  output  DATA_W  debug read data, valid while dbg_ack=1.
REQ-013 SHALL have port init_busy  output  1  high while the memory-clear sequence runs.

Function
REQ-014 SHALL use a main FSM with states INIT (clear in progress) and RUN (serving).
REQ-015 In RUN, wren=1 at an edge SHALL write data to mem[address_dmem] at that edge.
REQ-016 In RUN, q_dmem SHALL equal mem[address_dmem] as sampled at the previous edge (1-cycle latency), updated every cycle irrespective of wren.
REQ-017 Read and write to the same address in the same cycle SHALL return old data (read-before-write).
REQ-018 SHALL use a debug FSM with states D_IDLE and D_BUSY; D_IDLE->D_BUSY when dbg_req=1 and main FSM in RUN, dbg_addr captured then.
REQ-019 D_BUSY SHALL last exactly one cycle: dbg_ack=1 and dbg_rdata=mem[captured addr] as of the accept edge, then D_IDLE.
REQ-020 dbg_req still high at the ack cycle SHALL start a new accept on the following edge (max one debug read per 2 cycles).
REQ-021 Debug reads SHALL never stall, delay or alter processor-port behaviour; a same-cycle processor write to the captured address SHALL NOT affect dbg_rdata.
REQ-022 dbg_rdata SHALL hold its last value when dbg_ack=0.
REQ-023 In INIT: wren ignored, q_dmem=0, dbg_req not accepted, init_busy=1.

Reset
REQ-024 On reset: q_dmem=0, dbg_ack=0, dbg_rdata=0, debug FSM D_IDLE, any in-flight debug read discarded.
REQ-025 On reset the main FSM SHALL enter the state given by REQ-026/027; reset in any state (including mid-INIT) SHALL restart that sequence from its beginning.

Configuration
REQ-026 With macro DMEM_CLEAR_ON_RESET_EN defined: reset enters INIT, clear counter=0, init_busy=1; each cycle writes 0 to mem[counter] and increments; after writing word 2^ADDR_W-1 the FSM enters RUN (init_busy=0 in the cycle after the final write; INIT lasts exactly 2^ADDR_W cycles).
REQ-027 Without DMEM_CLEAR_ON_RESET_EN: reset enters RUN directly, memory contents preserved across reset, init_busy tied 0, INIT state and clear counter absent.

Verification
REQ-028 Store/load: RUN, write 345 to addr 1 and 567 to addr 2, then read addr 1, addr 2 -> q_dmem=345 then 567, each one cycle after the address cycle.
REQ-029 Read-before-write: mem[5]=0x11, same cycle wren=1 addr 5 data 0x22 -> q_dmem=0x11 next cycle; read addr 5 next -> 0x22.
REQ-030 Debug: mem[7]=0xDEADBEEF, dbg_req=1 dbg_addr=7 for one cycle while processor writes 0x1 to addr 7 -> dbg_ack pulse one cycle later, dbg_rdata=0xDEADBEEF; held dbg_req -> acks every 2nd cycle.
REQ-031 With DMEM_CLEAR_ON_RESET_EN, ADDR_W=4: preload nonzero, reset 1 cycle -> init_busy=1 for exactly 16 cycles, writes/dbg_req ignored meanwhile, afterwards all 16 words read 0.
REQ-032 Reset mid-INIT (ADDR_W=4, cycle 8) -> init_busy stays high 16 more cycles from reset release; without macro, reset preserves mem[3]=0xA5 and init_busy stays 0.
